// File: rtl/berger_pkg.sv
// Shared definitions for the Berger-one coded 16x12 word memory.
// Holds the codeword field layout, scrub FSM state encoding and the
// popcount helper shared by the checker and the encoder.
package berger_pkg;

  // Codeword geometry: {data[7:0], check[3:0]}
  localparam int BERGER_DATA_W = 8;
  localparam int BERGER_CHK_W  = 4;
  localparam int BERGER_DEPTH  = 16;
  localparam int BERGER_ADDR_W = 4;

  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 4;
  localparam int CHK_MSB  = 3;
  localparam int CHK_LSB  = 0;

  // Scrub controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scrub_state_e;

  // Number of ones in a data byte, sized to the check field.
  function automatic logic [BERGER_CHK_W-1:0] popcount(
    input logic [BERGER_DATA_W-1:0] d
  );
    logic [BERGER_CHK_W-1:0] n;
    n = '0;
    for (int i = 0; i < BERGER_DATA_W; i++) begin
      n = n + {{(BERGER_CHK_W-1){1'b0}}, d[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/berger_one_check.sv
// Purpose : flags a codeword whose check field differs from the ones-count of its data byte.
// Latency : combinational, no clock.
// Backpressure: none; pure function of the codeword.
// Ports   : codeword_i - 12-bit codeword {data, check}; err_o - 1 when the code is inconsistent.
module berger_one_check
  import berger_pkg::*;
(
  input  logic [DATA_MSB:0] codeword_i,
  output logic              err_o
);

  // Compared at full check width, so check values above 8 can never match.
  assign err_o = (popcount(codeword_i[DATA_MSB:DATA_LSB]) != codeword_i[CHK_MSB:CHK_LSB]);

endmodule

// File: rtl/berger_one_scrubber.sv
// Purpose : sweeps the 16-word Berger memory, checks every word and reports error stats.
// Latency : one pass = DEPTH scan cycles + drain + done (18 cycles), +1 per host stall cycle.
// Backpressure: host writes own the memory port and stall the sweep for that cycle.
// Ports   : clk/rst (async, active-high); start pulse, cont level; host_* write request;
//           mem_* memory port (combinational read data back on mem_rdata);
//           busy, done pulse, err_count, err_map, err_valid, first_err_addr status.
module berger_one_scrubber
  import berger_pkg::*;
#(
  parameter int DATA_W = BERGER_DATA_W,
  parameter int CHK_W  = BERGER_CHK_W,
  parameter int DEPTH  = BERGER_DEPTH,
  parameter int ADDR_W = BERGER_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    host_wr_en,
  input  logic [ADDR_W-1:0]       host_addr,
  input  logic [DATA_W+CHK_W-1:0] host_wdata,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W+CHK_W-1:0] mem_wdata,
  input  logic [DATA_W+CHK_W-1:0] mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W:0]         err_count,
  output logic [DEPTH-1:0]        err_map,
  output logic                    err_valid,
  output logic [ADDR_W-1:0]       first_err_addr
);

  localparam int CW_W = DATA_W + CHK_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_e      state_q;
  logic [ADDR_W-1:0] scan_ptr_q;
  logic              busy_q;
  logic              done_q;

  // Check stage: one captured word waiting to be judged
  logic              chk_vld_q;
  logic [CW_W-1:0]   chk_word_q;
  logic [ADDR_W-1:0] chk_addr_q;
  logic              chk_err;

  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [DEPTH-1:0]  err_map_q, err_map_d;
  logic              err_valid_q, err_valid_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;

  // Host always wins the port; otherwise the sweep pointer drives a read.
  assign mem_wr_en = host_wr_en;
  assign mem_addr  = host_wr_en ? host_addr : scan_ptr_q;
  assign mem_wdata = host_wr_en ? host_wdata : '0;

  berger_one_check u_check (
    .codeword_i (chk_word_q),
    .err_o      (chk_err)
  );

  // Stats update from the retiring check-stage word
  always_comb begin
    err_count_d      = err_count_q;
    err_map_d        = err_map_q;
    err_valid_d      = err_valid_q;
    first_err_addr_d = first_err_addr_q;
    if (chk_vld_q && chk_err) begin
      err_count_d           = err_count_q + {{ADDR_W{1'b0}}, 1'b1};
      err_map_d[chk_addr_q] = 1'b1;
      if (!err_valid_q) begin
        err_valid_d      = 1'b1;
        first_err_addr_d = chk_addr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      scan_ptr_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      chk_vld_q        <= 1'b0;
      chk_word_q       <= '0;
      chk_addr_q       <= '0;
      err_count_q      <= '0;
      err_map_q        <= '0;
      err_valid_q      <= 1'b0;
      first_err_addr_q <= '0;
    end else begin
      done_q           <= 1'b0;
      chk_vld_q        <= 1'b0;
      err_count_q      <= err_count_d;
      err_map_q        <= err_map_d;
      err_valid_q      <= err_valid_d;
      first_err_addr_q <= first_err_addr_d;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q          <= ST_SCAN;
            busy_q           <= 1'b1;
            scan_ptr_q       <= '0;
            err_count_q      <= '0;
            err_map_q        <= '0;
            err_valid_q      <= 1'b0;
            first_err_addr_q <= '0;
          end
        end

        ST_SCAN: begin
          // A host write this cycle means mem_rdata is not our word: hold.
          if (!host_wr_en) begin
            chk_vld_q  <= 1'b1;
            chk_word_q <= mem_rdata;
            chk_addr_q <= scan_ptr_q;
            scan_ptr_q <= scan_ptr_q + 1'b1;
            if (scan_ptr_q == LAST_ADDR) begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // Last word retires on this edge via the *_d path.
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end

        ST_DONE: begin
          if (cont) begin
            state_q          <= ST_SCAN;
            scan_ptr_q       <= '0;
            err_count_q      <= '0;
            err_map_q        <= '0;
            err_valid_q      <= 1'b0;
            first_err_addr_q <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign err_map        = err_map_q;
  assign err_valid      = err_valid_q;
  assign first_err_addr = first_err_addr_q;

endmodule
